// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU memory-port arbiter.
package cpu_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch-versus-data choice: data wins ties unless fetch has waited out a full streak.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STREAK = 3
) (
    input  logic             fReq,
    input  logic             dReq,
    input  logic [LAT_W-1:0] streak,
    output logic             pickF,
    output logic             pickD
);

    localparam logic [LAT_W-1:0] STREAK_MAX = LAT_W'(MAX_STREAK);

    always_comb begin
        pickD = dReq && !(fReq && (streak == STREAK_MAX));
        pickF = fReq && !pickD;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the data path,
// one transaction in flight, response after MEM_LAT cycles.
//
//  state  | meaning
//  IDLE   | port free; a request is granted combinationally this cycle
//  BUSY_F | fetch in flight; lat_cnt counts down to its response cycle
//  BUSY_D | ld/st in flight; lat_cnt counts down to its completion cycle
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_TC     = LAT_W'(1);
    localparam logic [LAT_W-1:0] STREAK_MAX = LAT_W'(MAX_STREAK);

    arb_state_t       state, stateNext;
    logic [LAT_W-1:0] latCnt, latCntNext;
    logic [LAT_W-1:0] streak, streakNext;
    logic             discard, discardNext;
    logic             weLat, weLatNext;
    logic             pickF, pickD;
    logic             lastCycle;

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) uPick (
        .fReq  (f_req),
        .dReq  (d_req),
        .streak(streak),
        .pickF (pickF),
        .pickD (pickD)
    );

    assign lastCycle = (latCnt == LAT_TC);

    always_comb begin
        stateNext   = state;
        latCntNext  = latCnt;
        discardNext = discard;
        weLatNext   = weLat;
        f_gnt       = 1'b0;
        f_rvalid    = 1'b0;
        f_rdata     = '0;
        d_gnt       = 1'b0;
        d_done      = 1'b0;
        d_rdata     = '0;
        m_req       = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;

        // Outputs stay quiet while reset is held so a dropped transaction never responds.
        if (!reset) begin
            case (state)
                IDLE: begin
                    discardNext = 1'b0;
                    if (pickD) begin
                        d_gnt      = 1'b1;
                        m_req      = 1'b1;
                        m_we       = d_we;
                        m_addr     = d_addr;
                        m_wdata    = d_wdata;
                        weLatNext  = d_we;
                        latCntNext = LAT_INIT;
                        stateNext  = BUSY_D;
                    end else if (pickF) begin
                        f_gnt       = 1'b1;
                        m_req       = 1'b1;
                        m_addr      = f_addr;
                        weLatNext   = 1'b0;
                        discardNext = f_flush;
                        latCntNext  = LAT_INIT;
                        stateNext   = BUSY_F;
                    end
                end
                BUSY_F: begin
                    latCntNext = latCnt - LAT_TC;
                    if (lastCycle) begin
                        f_rvalid    = !(discard || f_flush);
                        f_rdata     = f_rvalid ? m_rdata : '0;
                        discardNext = 1'b0;
                        stateNext   = IDLE;
                    end else begin
                        discardNext = discard || f_flush;
                    end
                end
                BUSY_D: begin
                    latCntNext = latCnt - LAT_TC;
                    if (lastCycle) begin
                        d_done    = 1'b1;
                        d_rdata   = weLat ? '0 : m_rdata;
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    latCntNext = '0;
                end
            endcase
        end
    end

    always_comb begin
        streakNext = streak;
        if (!f_req || f_gnt) begin
            streakNext = '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streakNext = streak + LAT_TC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            latCnt  <= '0;
            streak  <= '0;
            discard <= 1'b0;
            weLat   <= 1'b0;
        end else begin
            state   <= stateNext;
            latCnt  <= latCntNext;
            streak  <= streakNext;
            discard <= discardNext;
            weLat   <= weLatNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req, f_flush, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_rvalid, d_gnt, d_done, m_req, m_we;
    logic [15:0] f_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        f_req1;
    logic [15:0] f_addr1;
    logic        f_gnt1, f_rvalid1, d_gnt1, d_done1, m_req1, m_we1;
    logic [15:0] f_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;

    logic [15:0] mem [0:255];
    logic [15:0] rdP1, rdP2, rd1;
    logic [7:0]  pat;
    int          nTests;
    int          nFail;

    mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(3)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(3)) dut1 (
        .clk(clk), .reset(reset),
        .f_req(f_req1), .f_addr(f_addr1), .f_flush(1'b0),
        .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
        .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes land at accept, reads return MEM_LAT cycles later.
    always @(posedge clk) begin
        if (reset) begin
            mem[1] <= 16'hABCD;
        end else if (m_req && m_we) begin
            mem[m_addr[11:4]] <= m_wdata;
        end
        rdP1 <= (m_req && !m_we) ? mem[m_addr[11:4]] : 16'hBEEF;
        rdP2 <= rdP1;
        rd1  <= m_req1 ? mem[m_addr1[11:4]] : 16'hBEEF;
    end
    assign m_rdata  = rdP2;
    assign m_rdata1 = rd1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        reset = 1'b1;
        f_req = 1'b0; f_flush = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        f_req1 = 1'b0; f_addr1 = '0;
        repeat (3) step;
        reset = 1'b0;
        settle;
        chk("rst_ctrl", {f_gnt, f_rvalid, d_gnt, d_done, m_req, m_we}, 0);
        chk("rst_data", f_rdata | d_rdata | m_addr | m_wdata, 0);

        // single fetch
        step; f_req = 1'b1; f_addr = 16'h0010; settle;
        chk("t1_fgnt", f_gnt, 1);
        chk("t1_mem", {m_req, m_we, m_addr}, {1'b1, 1'b0, 16'h0010});
        chk("t1_dgnt", d_gnt, 0);
        step; f_req = 1'b0; settle;
        chk("t1_wait", f_rvalid, 0);
        step; settle;
        chk("t1_resp", {f_rvalid, f_rdata}, {1'b1, 16'hABCD});

        // store then load
        step; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234; settle;
        chk("t2_st_gnt", {d_gnt, m_req, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 1'b1, 16'h0100, 16'h1234});
        chk("t1_idle_rv", f_rvalid, 0);
        step; d_we = 1'b0; settle;
        chk("t2_busy", d_gnt, 0);
        step; settle;
        chk("t2_st_done", {d_done, d_rdata, d_gnt}, {1'b1, 16'h0000, 1'b0});
        step; settle;
        chk("t2_ld_gnt", {d_gnt, m_req, m_we, m_addr}, {1'b1, 1'b1, 1'b0, 16'h0100});
        step; d_req = 1'b0; settle;
        step; settle;
        chk("t2_ld_done", {d_done, d_rdata}, {1'b1, 16'h1234});

        // tie: both held, grant order D,D,D,F,D,D,D,F
        step; f_req = 1'b1; f_addr = 16'h0030; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        pat = 8'h88;
        for (int k = 0; k < 8; k++) begin
            settle;
            chk($sformatf("t3_slot%0d", k), {f_gnt, d_gnt}, pat[k] ? 2'b10 : 2'b01);
            step; step; step;
        end
        f_req = 1'b0; d_req = 1'b0; settle;
        chk("t3_idle", {f_gnt, d_gnt}, 0);

        // flush one cycle after accept
        step; f_req = 1'b1; f_addr = 16'h0010; settle;
        chk("t4a_gnt", f_gnt, 1);
        step; f_req = 1'b0; f_flush = 1'b1; settle;
        step; f_flush = 1'b0; settle;
        chk("t4a_supp", {f_rvalid, f_rdata}, 0);
        step; f_req = 1'b1; settle;
        chk("t4b_gnt", f_gnt, 1);
        step; f_req = 1'b0; settle;
        step; settle;
        chk("t4b_resp", {f_rvalid, f_rdata}, {1'b1, 16'hABCD});
        // flush in the accept cycle
        step; f_req = 1'b1; f_flush = 1'b1; settle;
        chk("t4c_gnt", f_gnt, 1);
        step; f_req = 1'b0; f_flush = 1'b0; settle;
        step; settle;
        chk("t4c_supp", f_rvalid, 0);
        // flush in the response cycle
        step; f_req = 1'b1; settle;
        chk("t4d_gnt", f_gnt, 1);
        step; f_req = 1'b0; settle;
        step; f_flush = 1'b1; settle;
        chk("t4d_supp", f_rvalid, 0);
        // flush does not touch data
        step; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; settle;
        chk("t4e_gnt", d_gnt, 1);
        step; d_req = 1'b0; settle;
        step; settle;
        chk("t4e_done", {d_done, d_rdata}, {1'b1, 16'h1234});
        step; f_flush = 1'b0;

        // reset during BUSY_D
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h5555; settle;
        chk("t5_gnt", d_gnt, 1);
        step; d_req = 1'b0; reset = 1'b1; settle;
        step; reset = 1'b0; settle;
        chk("t5_ctrl", {f_gnt, f_rvalid, d_gnt, d_done, m_req, m_we}, 0);
        chk("t5_data", f_rdata | d_rdata | m_addr | m_wdata, 0);
        f_req = 1'b1; f_addr = 16'h0010; #1;
        chk("t5_regnt", f_gnt, 1);
        step; f_req = 1'b0; settle;
        chk("t5_nodone", {d_done, f_rvalid}, 0);
        step; settle;
        chk("t5_resp", {f_rvalid, f_rdata}, {1'b1, 16'hABCD});

        // MEM_LAT=1: back-to-back fetches
        step; f_req1 = 1'b1; f_addr1 = 16'h0010;
        for (int k = 0; k < 6; k++) begin
            settle;
            chk($sformatf("t6_cyc%0d", k), {f_gnt1, f_rvalid1, f_rdata1},
                (k % 2 == 0) ? {2'b10, 16'h0000} : {2'b01, 16'hABCD});
            step;
        end
        f_req1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
